alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter MULDIV_CYCLES, default 4, number of EXEC cycles for multiply/divide ops (range 1-15).
REQ-002 Parameter NUM_REGS, default 8, architectural register count (fixed at 8 for 3-bit fields).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 instr_valid  input  1  instruction offered.
REQ-006 instr_ready  output  1  block can accept an instruction.
REQ-007 instr  input  16  [15:11] opcode, [10:8] rd, [7:5] rs1, [4:2] rs2, [7:0] imm8 (LDI only).
REQ-008 alu_a, alu_b  output  32  operands to the ALU.
REQ-009 alu_op  output  5  ALU operation select.
REQ-010 alu_result  input  32  combinational ALU result.
REQ-011 wb_valid  output  1  one-cycle pulse, writeback occurring.
REQ-012 wb_rd  output  3  writeback destination.
REQ-013 wb_data  output  32  writeback value.
REQ-014 illegal  output  1  one-cycle pulse, opcode rejected.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 dbg_addr  input  3 / dbg_data  output  32  combinational register-file read port.

Function
REQ-017 FSM states IDLE, EXEC, WB; instr_ready = 1 only in IDLE.
REQ-018 Handshake completes on a rising edge with instr_valid & instr_ready; instr is latched on that edge.
REQ-019 Opcodes 0-11 are ALU ops, passed unchanged on alu_op; opcode 12 is LDI; 13-31 illegal.
REQ-020 Illegal opcode: illegal pulses in the cycle after acceptance, state stays IDLE, no writeback, no register change.
REQ-021 ALU op: IDLE -> EXEC; during EXEC alu_a = R[rs1], alu_b = R[rs2], alu_op = opcode.
REQ-022 Ops 0-9 occupy exactly 1 EXEC cycle; ops 10-11 occupy exactly MULDIV_CYCLES EXEC cycles (internal down-counter).
REQ-023 alu_result is captured on the edge ending the final EXEC cycle; state -> WB.
REQ-024 LDI: IDLE -> WB directly, data = zero-extended imm8; ALU outputs stay zero.
REQ-025 WB lasts one cycle: wb_valid = 1, wb_rd = rd, wb_data = captured value; R[rd] written at end of WB; state -> IDLE.
REQ-026 R0 reads as zero always; writes to rd = 0 still pulse wb_valid with wb_data shown but leave R0 = 0.
REQ-027 Outside EXEC, alu_a, alu_b, alu_op drive zero.
REQ-028 Latency, acceptance edge at cycle 0: simple op wb_valid in cycle 2; mul/div in cycle 1+MULDIV_CYCLES; LDI in cycle 1; next acceptance possible the cycle after WB.
REQ-029 rs1/rs2 = rd permitted; operands read old value (no hazard, serial issue).
REQ-030 dbg_data reflects writes from the cycle after WB.

Reset
REQ-031 reset asserted: next edge forces IDLE, all registers R0-R7 = 0, counter = 0, captured data = 0; outputs wb_valid, illegal, busy, alu_* = 0, instr_ready = 1 the cycle after.
REQ-032 reset in EXEC or WB aborts the instruction; no register write occurs, wb_valid not pulsed; reset takes priority over handshake.

Structure
REQ-033 Package alu_ctrl_pkg holds opcode constants (ALU 0-11, OP_LDI = 12), FSM state encoding, and instruction field bit positions.
REQ-034 Register file is sub-module reg_file_8x32: 2 combinational read ports plus dbg port, 1 synchronous write port, R0 hardwired zero.
REQ-035 ALU is external; this block has no arithmetic other than the cycle counter.

Verification
REQ-036 LDI R1,0x05; LDI R2,0x03; ADD(op0) R3,R1,R2 with a reference ALU -> wb_data = 8, dbg R3 = 8, wb_valid in cycle 2 after ADD acceptance.
REQ-037 MUL(op10) R4,R1,R2 with MULDIV_CYCLES=4 -> alu_op = 10 held 4 cycles, wb_valid in cycle 5, R4 = 15.
REQ-038 instr_valid held high with opcode 20 -> illegal one-cycle pulse, registers unchanged, instr_ready back high next cycle.
REQ-039 LDI R0,0xFF -> wb_valid = 1, wb_data = 0xFF, dbg R0 = 0.
REQ-040 Reset asserted in 2nd EXEC cycle of DIV(op11) R5 -> no wb_valid, R5 = 0, instr_ready = 1 after reset.
REQ-041 Back-to-back instr_valid = 1 -> instr_ready low through EXEC/WB, exactly one instruction per handshake, none dropped or duplicated.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, FSM encoding and
// instruction field positions.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 11;
  localparam int RD_HI  = 10;
  localparam int RD_LO  = 8;
  localparam int RS1_HI = 7;
  localparam int RS1_LO = 5;
  localparam int RS2_HI = 4;
  localparam int RS2_LO = 2;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SLL  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_SLT  = 5'd8;
  localparam logic [4:0] OP_SLTU = 5'd9;
  localparam logic [4:0] OP_MUL  = 5'd10;
  localparam logic [4:0] OP_DIV  = 5'd11;
  localparam logic [4:0] OP_LDI  = 5'd12;

  function automatic logic is_alu_op(input logic [4:0] op);
    return op <= OP_DIV;
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/reg_file_8x32.sv
// Eight 32-bit architectural registers: two operand read ports, a debug read
// port and one synchronous write port. R0 always reads zero.
module reg_file_8x32 #(
  parameter int NUM_REGS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  raddr_a,
  output logic [31:0] rdata_a,
  input  logic [2:0]  raddr_b,
  output logic [31:0] rdata_b,
  input  logic [2:0]  dbg_addr,
  output logic [31:0] dbg_data,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != 3'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a  = (raddr_a == 3'd0) ? '0 : regs[raddr_a];
    rdata_b  = (raddr_b == 3'd0) ? '0 : regs[raddr_b];
    dbg_data = (dbg_addr == 3'd0) ? '0 : regs[dbg_addr];
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Serial issue controller for an external ALU: accepts one instruction at a
// time, sequences operand read, multi-cycle execute and register writeback.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | ready for a new instruction; illegal opcodes stay here
// ST_EXEC | operands on the ALU; down-counter sets the cycle count
// ST_WB   | one-cycle writeback of the captured value to R[rd]
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int MULDIV_CYCLES = 4,
  parameter int NUM_REGS      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_op,
  input  logic [31:0] alu_result,
  output logic        wb_valid,
  output logic [2:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        illegal,
  output logic        busy,
  input  logic [2:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  localparam logic [3:0] CNT_LOAD = 4'(MULDIV_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] instr_q;
  logic [3:0]  cnt_q;
  logic [31:0] data_q;
  logic        illegal_q;

  logic [4:0]  opc_in, opc_q;
  logic [7:0]  imm_in;
  logic [2:0]  rd_q, rs1_q, rs2_q;
  logic        accept, exec_done, wb_fire;
  logic [31:0] rdata_a, rdata_b;

  assign opc_in    = instr[OPC_HI:OPC_LO];
  assign imm_in    = instr[IMM_HI:IMM_LO];
  assign opc_q     = instr_q[OPC_HI:OPC_LO];
  assign rd_q      = instr_q[RD_HI:RD_LO];
  assign rs1_q     = instr_q[RS1_HI:RS1_LO];
  assign rs2_q     = instr_q[RS2_HI:RS2_LO];
  assign accept    = instr_valid && instr_ready;
  assign exec_done = (cnt_q == 4'd0);
  // Reset in WB suppresses both the pulse and the write in that same cycle.
  assign wb_fire   = (state_q == ST_WB) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_alu_op(opc_in)) begin
            state_d = ST_EXEC;
          end else if (opc_in == OP_LDI) begin
            state_d = ST_WB;
          end
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          state_d = ST_WB;
        end
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state_q == ST_IDLE);
    busy        = (state_q != ST_IDLE);
    illegal     = illegal_q;
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = '0;
    wb_valid    = wb_fire;
    wb_rd       = '0;
    wb_data     = '0;
    if (state_q == ST_EXEC) begin
      alu_a  = rdata_a;
      alu_b  = rdata_b;
      alu_op = opc_q;
    end
    if (wb_fire) begin
      wb_rd   = rd_q;
      wb_data = data_q;
    end
  end

  // Counter holds remaining EXEC cycles after the current one.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q   <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= accept && !is_alu_op(opc_in) && (opc_in != OP_LDI);
      if (accept) begin
        instr_q <= instr;
        cnt_q   <= is_muldiv(opc_in) ? CNT_LOAD : 4'd0;
        if (opc_in == OP_LDI) begin
          data_q <= {24'd0, imm_in};
        end
      end else if (state_q == ST_EXEC) begin
        if (exec_done) begin
          data_q <= alu_result;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
      end
    end
  end

  reg_file_8x32 #(
    .NUM_REGS(NUM_REGS)
  ) u_reg_file (
    .clk     (clk),
    .reset   (reset),
    .raddr_a (rs1_q),
    .rdata_a (rdata_a),
    .raddr_b (rs2_q),
    .rdata_b (rdata_b),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data),
    .we      (wb_fire),
    .waddr   (rd_q),
    .wdata   (data_q)
  );

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed scenarios plus random instruction
// streams checked against an architectural register/latency model.
module tb_alu_issue_ctrl;

  localparam int MC = 4;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [4:0]  alu_op;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;
  logic        busy;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] model [8];

  alu_issue_ctrl #(
    .MULDIV_CYCLES(MC),
    .NUM_REGS     (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .illegal    (illegal),
    .busy       (busy),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a ^ b;
      5'd5:    return a << b[4:0];
      5'd6:    return a >> b[4:0];
      5'd7:    return $signed(a) >>> b[4:0];
      5'd8:    return {31'd0, $signed(a) < $signed(b)};
      5'd9:    return {31'd0, a < b};
      5'd10:   return a * b;
      5'd11:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return 32'd0;
    endcase
  endfunction

  always_comb alu_result = ref_alu(alu_op, alu_a, alu_b);

  function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 2'b00};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [7:0] imm);
    return {5'd12, rd, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) model[i] = 32'd0;
  endtask

  task automatic check_reg(input string tag, input logic [2:0] r, input logic [31:0] exp);
    dbg_addr = r;
    #1;
    check(tag, dbg_data, exp);
  endtask

  // Offers one instruction and follows it to completion. With hold set,
  // instr_valid stays high afterwards so the next call runs back-to-back.
  task automatic run_instr(input logic [15:0] ins, input bit hold);
    logic [4:0]  op;
    logic [2:0]  rd, rs1, rs2;
    logic [31:0] a, b, exp;
    int          lat;
    op  = ins[15:11];
    rd  = ins[10:8];
    rs1 = ins[7:5];
    rs2 = ins[4:2];
    a   = model[rs1];
    b   = model[rs2];
    exp = (op == 5'd12) ? {24'd0, ins[7:0]} : ref_alu(op, a, b);
    lat = (op == 5'd12) ? 1 : ((op == 5'd10 || op == 5'd11) ? 1 + MC : 2);

    @(negedge clk);
    instr       = ins;
    instr_valid = 1'b1;
    check1("ready_before_accept", instr_ready, 1'b1);
    @(posedge clk);
    #1;
    if (!hold) instr_valid = 1'b0;

    if (op > 5'd12) begin
      check1("illegal_pulse", illegal, 1'b1);
      check1("illegal_no_wb", wb_valid, 1'b0);
      check1("illegal_not_busy", busy, 1'b0);
      check1("illegal_ready", instr_ready, 1'b1);
      check_reg("illegal_reg_kept", rd, model[rd]);
    end else begin
      for (int c = 1; c < lat; c++) begin
        check1("exec_busy", busy, 1'b1);
        check1("exec_not_ready", instr_ready, 1'b0);
        check1("exec_no_wb", wb_valid, 1'b0);
        check("exec_alu_op", 32'(alu_op), 32'(op));
        check("exec_alu_a", alu_a, a);
        check("exec_alu_b", alu_b, b);
        @(posedge clk);
        #1;
      end
      check1("wb_valid", wb_valid, 1'b1);
      check("wb_rd", 32'(wb_rd), 32'(rd));
      check("wb_data", wb_data, exp);
      check("wb_alu_op_zero", 32'(alu_op), 32'd0);
      check("wb_alu_a_zero", alu_a, 32'd0);
      check1("wb_no_illegal", illegal, 1'b0);
      if (rd != 3'd0) model[rd] = exp;
      @(posedge clk);
      #1;
      check1("post_wb_valid_low", wb_valid, 1'b0);
      check1("post_wb_ready", instr_ready, 1'b1);
      check_reg("post_wb_dbg", rd, model[rd]);
    end
  endtask

  initial begin
    logic [4:0] rop;
    logic [2:0] rrd, rr1, rr2;
    int         pick;

    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'd0;
    dbg_addr    = 3'd0;
    clear_model();

    repeat (2) @(posedge clk);
    #1;
    check1("rst_ready", instr_ready, 1'b1);
    check1("rst_busy", busy, 1'b0);
    check1("rst_wb_valid", wb_valid, 1'b0);
    check1("rst_illegal", illegal, 1'b0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    reset = 1'b0;
    check_reg("rst_r3", 3'd3, 32'd0);

    // LDI/LDI/ADD sequence
    run_instr(ldi(3'd1, 8'h05), 1'b0);
    run_instr(ldi(3'd2, 8'h03), 1'b0);
    run_instr(enc(5'd0, 3'd3, 3'd1, 3'd2), 1'b0);
    check_reg("add_r3_is_8", 3'd3, 32'd8);

    // Multi-cycle multiply
    run_instr(enc(5'd10, 3'd4, 3'd1, 3'd2), 1'b0);
    check_reg("mul_r4_is_15", 3'd4, 32'd15);

    // Illegal opcode with valid held, then an instruction right behind it
    run_instr(enc(5'd20, 3'd1, 3'd2, 3'd3), 1'b1);
    run_instr(ldi(3'd6, 8'h42), 1'b1);
    instr_valid = 1'b0;
    check_reg("illegal_r1_kept", 3'd1, 32'd5);

    // Write to R0 is shown but discarded
    run_instr(ldi(3'd0, 8'hFF), 1'b0);
    check_reg("r0_stays_zero", 3'd0, 32'd0);

    // Source equals destination
    run_instr(enc(5'd0, 3'd1, 3'd1, 3'd1), 1'b0);
    check_reg("self_add_r1", 3'd1, 32'd10);

    // Back-to-back held valid, then confirm nothing is replayed
    run_instr(enc(5'd1, 3'd5, 3'd4, 3'd1), 1'b1);
    run_instr(enc(5'd11, 3'd6, 3'd4, 3'd2), 1'b1);
    run_instr(ldi(3'd7, 8'h80), 1'b1);
    instr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check1("no_duplicate_wb", wb_valid, 1'b0);
      check1("no_duplicate_busy", busy, 1'b0);
    end

    // Reset during the second EXEC cycle of a divide
    run_instr(ldi(3'd1, 8'd20), 1'b0);
    run_instr(ldi(3'd2, 8'd3), 1'b0);
    @(negedge clk);
    instr       = enc(5'd11, 3'd5, 3'd1, 3'd2);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    check("div_exec1_op", 32'(alu_op), 32'd11);
    @(posedge clk);
    #1;
    check("div_exec2_op", 32'(alu_op), 32'd11);
    reset = 1'b1;
    #1;
    check1("div_rst_no_wb", wb_valid, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_model();
    check1("div_rst_ready", instr_ready, 1'b1);
    check1("div_rst_busy", busy, 1'b0);
    check("div_rst_alu_op", 32'(alu_op), 32'd0);
    check_reg("div_rst_r5", 3'd5, 32'd0);
    check_reg("div_rst_r1", 3'd1, 32'd0);
    for (int i = 0; i < MC; i++) begin
      @(posedge clk);
      #1;
      check1("div_rst_no_late_wb", wb_valid, 1'b0);
    end

    // Random instruction stream
    for (int n = 0; n < 60; n++) begin
      pick = int'($urandom_range(0, 9));
      rrd  = 3'($urandom_range(0, 7));
      rr1  = 3'($urandom_range(0, 7));
      rr2  = 3'($urandom_range(0, 7));
      if (pick == 0) begin
        rop = 5'($urandom_range(13, 31));
        run_instr(enc(rop, rrd, rr1, rr2), 1'($urandom_range(0, 1)));
      end else if (pick < 4) begin
        run_instr(ldi(rrd, 8'($urandom_range(0, 255))), 1'($urandom_range(0, 1)));
      end else begin
        rop = 5'($urandom_range(0, 11));
        run_instr(enc(rop, rrd, rr1, rr2), 1'($urandom_range(0, 1)));
      end
    end
    instr_valid = 1'b0;
    for (int r = 0; r < 8; r++) begin
      check_reg("final_reg", 3'(r), model[r]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
